// File: rtl/norm_pkg.sv
// Shared constants, leading-zero width helper and result-flag type for the normalising shift pipe.
package norm_pkg;

   localparam int unsigned NORM_MANT_W = 25;
   localparam int unsigned NORM_EXP_W  = 8;

   // Bits needed to hold a leading-zero count of 0..w inclusive.
   function automatic int unsigned lz_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   typedef struct packed {
      logic zero;
      logic uflow;
      logic subn;
   } norm_flags_t;

endpackage

// File: rtl/norm_shift_pipe_if.sv
// Input/output handshake bundle for norm_shift_pipe; slave is the pipe's view, master the driver's.
interface norm_shift_pipe_if
   import norm_pkg::*;
#(
   parameter int unsigned MANT_W = NORM_MANT_W,
   parameter int unsigned EXP_W  = NORM_EXP_W
);
   logic              in_valid;
   logic              in_ready;
   logic [MANT_W-1:0] in_sig;
   logic [EXP_W-1:0]  in_exp;
   logic              out_valid;
   logic              out_ready;
   logic [MANT_W-1:0] out_sig;
   logic [EXP_W-1:0]  out_exp;
   logic              out_sign;
   logic              out_zero;
   logic              out_uflow;
   logic              out_subn;

   modport slave (
      input  in_valid, in_sig, in_exp, out_ready,
      output in_ready, out_valid, out_sig, out_exp, out_sign, out_zero, out_uflow, out_subn
   );

   modport master (
      output in_valid, in_sig, in_exp, out_ready,
      input  in_ready, out_valid, out_sig, out_exp, out_sign, out_zero, out_uflow, out_subn
   );
endinterface

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module norm_lzc
   import norm_pkg::*;
#(
   parameter int unsigned W    = NORM_MANT_W,
   parameter int unsigned LZ_W = lz_width(W)
) (
   input  logic [W-1:0]    i_val,
   output logic [LZ_W-1:0] o_lz
);

   // Scan upward so the highest set bit is the last to write the count.
   always_comb begin
      o_lz = LZ_W'(W);
      for (int i = 0; i < int'(W); i++) begin
         if (i_val[i]) o_lz = LZ_W'(int'(W) - 1 - i);
      end
   end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage sign-magnitude normaliser with valid/ready flow control.
// Define NORM_SUBNORMAL_EN to keep exponent-underflow results as subnormals instead of flushing them.
module norm_shift_pipe
   import norm_pkg::*;
#(
   parameter int unsigned MANT_W = NORM_MANT_W,
   parameter int unsigned EXP_W  = NORM_EXP_W
) (
   input  logic              clk,
   input  logic              rst,
   norm_shift_pipe_if.slave  bus
);

   localparam int unsigned LZ_W = lz_width(MANT_W);
   localparam int unsigned CW   = (EXP_W > LZ_W) ? EXP_W : LZ_W;

   logic              r_s1_valid;
   logic              r_s1_sign;
   logic [MANT_W-1:0] r_s1_mag;
   logic [EXP_W-1:0]  r_s1_exp;

   logic              r_s2_valid;
   logic              r_s2_sign;
   logic [MANT_W-1:0] r_s2_sig;
   logic [EXP_W-1:0]  r_s2_exp;
   norm_flags_t       r_s2_flags;

   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_in_sign;
   logic [LZ_W-1:0]   w_lz;
   logic              w_zero;
   logic              w_under;
   logic [MANT_W-1:0] w_sig;
   logic [EXP_W-1:0]  w_exp;
   norm_flags_t       w_flags;

   assign w_s2_adv  = !r_s2_valid || bus.out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign w_in_sign = bus.in_sig[MANT_W-1];

   // Stage 1: split into sign and magnitude.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_mag   <= '0;
         r_s1_exp   <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_sign <= w_in_sign;
            r_s1_mag  <= w_in_sign ? MANT_W'(-bus.in_sig) : bus.in_sig;
            r_s1_exp  <= bus.in_exp;
         end
      end
   end

   norm_lzc #(.W(MANT_W), .LZ_W(LZ_W)) u_lzc (
      .i_val (r_s1_mag),
      .o_lz  (w_lz)
   );

   assign w_zero  = (r_s1_mag == '0);
   assign w_under = !w_zero && (CW'(w_lz) > CW'(r_s1_exp));

   // Stage 2 datapath: shift by the leading-zero count unless the exponent cannot absorb it.
   always_comb begin
      w_sig   = r_s1_mag << w_lz;
      w_exp   = EXP_W'(CW'(r_s1_exp) - CW'(w_lz));
      w_flags = '0;
      if (w_zero) begin
         w_sig        = '0;
         w_exp        = '0;
         w_flags.zero = 1'b1;
      end else if (w_under) begin
`ifdef NORM_SUBNORMAL_EN
         w_sig        = r_s1_mag << r_s1_exp;
         w_exp        = '0;
         w_flags.subn = 1'b1;
`else
         w_sig         = '0;
         w_exp         = '0;
         w_flags.uflow = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
         r_s2_sig   <= '0;
         r_s2_exp   <= '0;
         r_s2_flags <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sign  <= r_s1_sign;
            r_s2_sig   <= w_sig;
            r_s2_exp   <= w_exp;
            r_s2_flags <= w_flags;
         end
      end
   end

   assign bus.in_ready  = w_s1_adv;
   assign bus.out_valid = r_s2_valid;
   assign bus.out_sig   = r_s2_sig;
   assign bus.out_exp   = r_s2_exp;
   assign bus.out_sign  = r_s2_sign;
   assign bus.out_zero  = r_s2_flags.zero;
   assign bus.out_uflow = r_s2_flags.uflow;
   assign bus.out_subn  = r_s2_flags.subn;

endmodule
